ps2_keyboard_fifo: RTL and testbench

Parametrised next-generation PS/2 keyboard receiver. It deserialises 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and flags framing, parity, timeout and overflow errors. Optionally it folds E0/F0 prefix bytes into extended/break flags. Received codes are buffered in a show-ahead FIFO for the consuming logic (display/scan-code decode).

---
 rtl/ps2_keyboard_fifo.sv | 159 +++++++++++++++
 tb/tb_ps2_keyboard_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, optionally folds E0/F0 prefixes, buffers codes in a show-ahead FIFO.
// Latency: an entry is visible on the first clk edge after the strobe cycle of the stop bit.
// Backpressure: none toward the device; when the FIFO is full a new entry is dropped and overflow is flagged.
module ps2_keyboard_fifo #(
   parameter int FIFO_AW        = 3,
   parameter int SYNC_STAGES    = 3,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int DECODE         = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   input  logic               rd_en,
   input  logic               clr_err,
   output logic [7:0]         data,
   output logic               ext,
   output logic               brk,
   output logic               valid,
   output logic [FIFO_AW:0]   count,
   output logic               overflow,
   output logic               parity_err,
   output logic               frame_err
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} dec_state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   strobe;
   logic [3:0]             bit_cnt;
   logic [9:0]             buffer;
   logic [TW-1:0]          to_cnt;
   logic                   timeout;
   logic                   frame_end, start_ok, stop_ok, par_ok, frame_ok, frame_bad;
   logic [7:0]             rx_byte;
   dec_state_t             state, state_nxt;
   logic                   push_vld;
   logic [9:0]             push_dat;
   logic [9:0]             mem [DEPTH];
   logic [FIFO_AW:0]       wr_ptr, rd_ptr;
   logic                   full, pop, wr_ok;
   logic [9:0]             head;

   // Synchronise ps2_clk; reset to all-ones so release never looks like a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '1;
      else     sync <= {sync[SYNC_STAGES-2:0], ps2_clk};
   end

   assign strobe    = sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES-2];
   assign frame_end = strobe && (bit_cnt == 4'd10);
   assign start_ok  = ~buffer[0];
   assign stop_ok   = ps2_data;
   assign par_ok    = ^buffer[9:1];
   assign frame_ok  = frame_end & start_ok & stop_ok & par_ok;
   assign frame_bad = frame_end & ~(start_ok & stop_ok & par_ok);
   assign rx_byte   = buffer[8:1];
   assign timeout   = ~strobe && (bit_cnt != 4'd0) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   // Bit collection and inactivity timeout; a stalled partial frame is abandoned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= 4'd0;
         buffer  <= '0;
         to_cnt  <= '0;
      end else if (strobe) begin
         to_cnt <= '0;
         if (bit_cnt == 4'd10) begin
            bit_cnt <= 4'd0;
         end else begin
            buffer[bit_cnt] <= ps2_data;
            bit_cnt         <= bit_cnt + 4'd1;
         end
      end else if (timeout) begin
         bit_cnt <= 4'd0;
         to_cnt  <= '0;
      end else if (bit_cnt != 4'd0) begin
         to_cnt <= to_cnt + TW'(1);
      end else begin
         to_cnt <= '0;
      end
   end

   // Prefix decoder state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Fold E0/F0 prefixes into ext/brk; raw mode pushes every accepted byte.
   always_comb begin
      logic hold;
      state_nxt = state;
      push_vld  = 1'b0;
      push_dat  = {2'b00, rx_byte};
      hold      = ((state == ST_IDLE) && ((rx_byte == 8'hE0) || (rx_byte == 8'hF0))) ||
                  ((state == ST_E0) && (rx_byte == 8'hF0));
      if (DECODE == 0) begin
         state_nxt = ST_IDLE;
         push_vld  = frame_ok;
      end else if (frame_bad) begin
         state_nxt = ST_IDLE;
      end else if (frame_ok) begin
         if (hold) begin
            if (state == ST_E0)            state_nxt = ST_E0F0;
            else if (rx_byte == 8'hE0)     state_nxt = ST_E0;
            else                           state_nxt = ST_F0;
         end else begin
            push_vld  = 1'b1;
            push_dat  = {(state == ST_F0) || (state == ST_E0F0),
                         (state == ST_E0) || (state == ST_E0F0), rx_byte};
            state_nxt = ST_IDLE;
         end
      end
   end

   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign valid = (count != '0);
   assign pop   = rd_en & valid;
   assign wr_ok = push_vld & (~full | pop);
   assign head  = mem[rd_ptr[FIFO_AW-1:0]];
   assign data  = valid ? head[7:0] : 8'h00;
   assign ext   = valid & head[8];
   assign brk   = valid & head[9];

   // FIFO storage; contents are qualified by valid so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= push_dat;
   end

   // FIFO pointers; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         overflow   <= (overflow & ~clr_err) | (push_vld & full & ~pop);
         parity_err <= (parity_err & ~clr_err) | (frame_end & ~par_ok);
         frame_err  <= (frame_err & ~clr_err) | (frame_end & ~(start_ok & stop_ok)) | timeout;
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Bench for ps2_keyboard_fifo: a decoding and a raw instance share one PS/2 bus.
// A frame-level model fills expected queues; monitors compare entries whenever rd_en pops.
// Directed scenarios are followed by a randomized frame stream with error injection.
module tb_ps2_keyboard_fifo;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int TO    = 300;

   logic          clk = 1'b0;
   logic          rst, ps2_clk, ps2_data, clr_err;
   logic          rd_en_d, rd_en_r;
   logic [7:0]    data_d, data_r;
   logic          ext_d, ext_r, brk_d, brk_r, valid_d, valid_r;
   logic [AW:0]   count_d, count_r;
   logic          ovf_d, ovf_r, perr_d, perr_r, ferr_d, ferr_r;

   int            checks = 0;
   int            errors = 0;

   logic [9:0]    qd[$];
   logic [9:0]    qr[$];
   bit            exp_ovf_d, exp_ovf_r, exp_perr, exp_ferr;
   bit            m_e, m_f;

   always #5 clk = ~clk;

   ps2_keyboard_fifo #(.FIFO_AW(AW), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO), .DECODE(1)) u_dec (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en_d),
      .clr_err(clr_err), .data(data_d), .ext(ext_d), .brk(brk_d), .valid(valid_d),
      .count(count_d), .overflow(ovf_d), .parity_err(perr_d), .frame_err(ferr_d));

   ps2_keyboard_fifo #(.FIFO_AW(AW), .SYNC_STAGES(3), .TIMEOUT_CYCLES(TO), .DECODE(0)) u_raw (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en_r),
      .clr_err(clr_err), .data(data_r), .ext(ext_r), .brk(brk_r), .valid(valid_r),
      .count(count_r), .overflow(ovf_r), .parity_err(perr_r), .frame_err(ferr_r));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: whenever rd_en is presented, the head must match the oldest expected entry.
   always @(negedge clk) begin
      #1;
      if (rd_en_d) begin
         chk("dec_pop_valid", 32'(valid_d), 32'(qd.size() != 0));
         if (valid_d && qd.size() != 0) chk("dec_pop_entry", 32'({brk_d, ext_d, data_d}), 32'(qd.pop_front()));
      end
      if (rd_en_r) begin
         chk("raw_pop_valid", 32'(valid_r), 32'(qr.size() != 0));
         if (valid_r && qr.size() != 0) chk("raw_pop_entry", 32'({brk_r, ext_r, data_r}), 32'(qr.pop_front()));
      end
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic push_d(input logic [9:0] e, input bit pop_end);
      if (qd.size() >= DEPTH && !pop_end) exp_ovf_d = 1'b1;
      else qd.push_back(e);
   endtask

   task automatic push_r(input logic [9:0] e, input bit pop_end);
      if (qr.size() >= DEPTH && !pop_end) exp_ovf_r = 1'b1;
      else qr.push_back(e);
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_end);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (6) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == n - 1 && pop_end) begin
            repeat (2) @(negedge clk);
            rd_en_d = 1'b1;
            rd_en_r = 1'b1;
            @(negedge clk);
            rd_en_d = 1'b0;
            rd_en_r = 1'b0;
            repeat (3) @(negedge clk);
         end else begin
            repeat (6) @(negedge clk);
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input bit bad_start, input bit pop_end);
      logic [10:0] bits;
      logic        par;
      par  = (~^b) ^ bad_par;
      bits = {~bad_stop, par, b, bad_start};
      if (!(bad_par || bad_stop || bad_start)) begin
         push_r({2'b00, b}, pop_end);
         if (b == 8'hE0 && !m_e && !m_f)  m_e = 1'b1;
         else if (b == 8'hF0 && !m_f)     m_f = 1'b1;
         else begin
            push_d({m_f, m_e, b}, pop_end);
            m_e = 1'b0;
            m_f = 1'b0;
         end
      end else begin
         if (bad_par) exp_perr = 1'b1;
         if (bad_stop || bad_start) exp_ferr = 1'b1;
         m_e = 1'b0;
         m_f = 1'b0;
      end
      send_bits(bits, 11, pop_end);
   endtask

   task automatic status(input string tag);
      chk({tag, "_count_d"}, 32'(count_d), 32'(qd.size()));
      chk({tag, "_count_r"}, 32'(count_r), 32'(qr.size()));
      chk({tag, "_valid_d"}, 32'(valid_d), 32'(qd.size() != 0));
      chk({tag, "_ovf_d"},   32'(ovf_d),   32'(exp_ovf_d));
      chk({tag, "_ovf_r"},   32'(ovf_r),   32'(exp_ovf_r));
      chk({tag, "_perr"},    32'({perr_d, perr_r}), 32'({exp_perr, exp_perr}));
      chk({tag, "_ferr"},    32'({ferr_d, ferr_r}), 32'({exp_ferr, exp_ferr}));
   endtask

   task automatic pop_one();
      @(negedge clk);
      rd_en_d = (qd.size() != 0);
      rd_en_r = (qr.size() != 0);
      @(negedge clk);
      rd_en_d = 1'b0;
      rd_en_r = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH + 2 && (qd.size() != 0 || qr.size() != 0); i++) pop_one();
      chk("drain_count", 32'({count_d, count_r}), 32'd0);
   endtask

   task automatic clear_errors();
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      exp_ovf_d = 1'b0;
      exp_ovf_r = 1'b0;
      exp_perr  = 1'b0;
      exp_ferr  = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_out_d"}, 32'({valid_d, count_d, data_d, ext_d, brk_d}), 32'd0);
      chk({tag, "_out_r"}, 32'({valid_r, count_r, data_r, ext_r, brk_r}), 32'd0);
      chk({tag, "_flags"}, 32'({ovf_d, perr_d, ferr_d, ovf_r, perr_r, ferr_r}), 32'd0);
   endtask

   initial begin
      logic [10:0] pbits;
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; clr_err = 1'b0;
      rd_en_d = 1'b0; rd_en_r = 1'b0;
      m_e = 1'b0; m_f = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single raw code 1C, then pop back to empty.
      frame(8'h1C, 0, 0, 0, 0);
      chk("t1_raw_head", 32'({valid_r, count_r, brk_r, ext_r, data_r}), 32'({1'b1, 4'd1, 2'b00, 8'h1C}));
      status("t1");
      pop_one();
      chk("t1_raw_empty", 32'({valid_r, count_r, data_r}), 32'd0);

      // Prefix folding: E0 F0 75, F0 1C.
      frame(8'hE0, 0, 0, 0, 0);
      frame(8'hF0, 0, 0, 0, 0);
      frame(8'h75, 0, 0, 0, 0);
      frame(8'hF0, 0, 0, 0, 0);
      frame(8'h1C, 0, 0, 0, 0);
      chk("t2_dec_count", 32'(count_d), 32'd2);
      chk("t2_dec_head", 32'({brk_d, ext_d, data_d}), 32'({2'b11, 8'h75}));
      status("t2");
      drain();

      // Parity and stop errors, clear, then a good frame.
      frame(8'h1C, 1, 0, 0, 0);
      chk("t3_perr", 32'({perr_d, valid_d, valid_r}), 32'({1'b1, 2'b00}));
      frame(8'h1C, 0, 1, 0, 0);
      chk("t3_ferr", 32'({ferr_d, ferr_r}), 32'b11);
      clear_errors();
      status("t3_clr");
      frame(8'h1C, 0, 0, 0, 0);
      status("t3_good");
      drain();

      // Fill past capacity, then a push coinciding with a pop at full.
      for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0, 0, 0);
      chk("t4_full", 32'({count_d, ovf_d}), 32'({4'd8, 1'b1}));
      status("t4_full");
      frame(8'h0A, 0, 0, 0, 1);
      chk("t4_pushpop", 32'({count_d, count_r}), 32'({4'd8, 4'd8}));
      status("t4_pushpop");
      drain();
      clear_errors();

      // Timeout after five bits; decoder state is left alone.
      pbits = {2'b11, 8'h2A, 1'b0};
      send_bits(pbits, 5, 0);
      repeat (TO + 10) @(negedge clk);
      exp_ferr = 1'b1;
      status("t5_timeout");
      frame(8'h2A, 0, 0, 0, 0);
      chk("t5_after", 32'({valid_d, data_d}), 32'({1'b1, 8'h2A}));
      status("t5_after");

      // Asynchronous reset mid-frame with data and errors pending.
      frame(8'h33, 1, 0, 0, 0);
      pbits = {2'b11, 8'h5A, 1'b0};
      send_bits(pbits, 6, 0);
      #3 rst = 1'b1;
      #1 check_all_zero("t6_rst");
      qd.delete(); qr.delete();
      exp_ovf_d = 1'b0; exp_ovf_r = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
      m_e = 1'b0; m_f = 1'b0;
      #17 rst = 1'b0;
      repeat (3) @(negedge clk);
      frame(8'h5A, 0, 0, 0, 0);
      chk("t6_after", 32'({valid_d, data_d, valid_r, data_r}), 32'({1'b1, 8'h5A, 1'b1, 8'h5A}));
      status("t6_after");
      drain();

      // Randomized stream with prefixes, injected errors, random pops and clears.
      for (int n = 0; n < 40; n++) begin
         logic [7:0] b;
         int         sel, err;
         sel = $urandom_range(0, 9);
         b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
         err = $urandom_range(0, 11);
         frame(b, err == 0, err == 1, err == 2, 0);
         status("rnd");
         if ($urandom_range(0, 2) != 0) pop_one();
         if ($urandom_range(0, 7) == 0) clear_errors();
      end
      drain();
      status("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
